ps2_key_decoder: RTL and testbench

//   PS/2 keyboard receiver and accelerate-key decoder; produces keyboard_in for game_controller.

---
 rtl/ps2_pkg.sv | 8 +
 rtl/ps2_rx_frame.sv | 115 +++++++++++
 rtl/ps2_key_decoder.sv | 96 +++++++++
 tb/tb_ps2_key_decoder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame-FSM encoding for the PS/2 keyboard receive path.
package ps2_pkg;
   localparam logic [7:0] SC_BREAK   = 8'hF0;
   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam int         FRAME_BITS = 11;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and 11-bit frame deserialiser with mid-frame timeout.
// byte_valid_o/byte_err_o are single-cycle strobes in the cycle the stop bit is sampled.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 65000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte_o,
   output logic       byte_valid_o,
   output logic       byte_err_o
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          filt_q, fall_q;
   logic [FW-1:0] filt_cnt_q;
   logic          dat;

   rx_state_e     state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_q, to_d;
   logic          timeout;

   assign dat = dat_sync_q[1];

   // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         fall_q     <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
         fall_q     <= 1'b0;
         if (clk_sync_q[1] == filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q     <= clk_sync_q[1];
            filt_cnt_q <= '0;
            fall_q     <= filt_q;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         to_q    <= to_d;
      end
   end

   assign timeout = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d      = state_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      par_d        = par_q;
      to_d         = (state_q == IDLE || fall_q) ? '0 : to_q + 1'b1;
      byte_valid_o = 1'b0;
      byte_err_o   = 1'b0;
      if (timeout) begin
         state_d    = IDLE;
         byte_err_o = 1'b1;
      end else if (fall_q) begin
         case (state_q)
            IDLE: begin
               if (!dat) begin
                  state_d = DATA;
                  bit_d   = '0;
               end
            end
            DATA: begin
               shift_d = {dat, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat && (^{shift_q, par_q})) byte_valid_o = 1'b1;
               else                            byte_err_o   = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign rx_byte_o = shift_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: tracks E0/F0 prefixes and turns fresh makes of KEY_CODE
// into a single-cycle key_pulse; typematic repeats only refresh scan_code.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter logic [7:0] KEY_CODE       = 8'h29,
   parameter int         FILTER_LEN     = 4,
   parameter int         TIMEOUT_CYCLES = 65000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_pulse,
   output logic       key_held,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_error
);
   logic [7:0] rx_byte;
   logic       byte_valid, byte_err;

   logic [7:0] scan_code_q;
   logic       scan_valid_q, frame_error_q;
   logic       key_pulse_q, key_pulse_d;
   logic       key_held_q, key_held_d;
   logic       ext_q, ext_d, brk_q, brk_d;

   ps2_rx_frame #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk          (clk),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .rx_byte_o    (rx_byte),
      .byte_valid_o (byte_valid),
      .byte_err_o   (byte_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_code_q   <= '0;
         scan_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         key_pulse_q   <= 1'b0;
         key_held_q    <= 1'b0;
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
      end else begin
         if (byte_valid) scan_code_q <= rx_byte;
         scan_valid_q  <= byte_valid;
         frame_error_q <= byte_err;
         key_pulse_q   <= key_pulse_d;
         key_held_q    <= key_held_d;
         ext_q         <= ext_d;
         brk_q         <= brk_d;
      end
   end

   // Protocol layer consumes the registered byte, so key_pulse lands one cycle after scan_valid.
   always_comb begin
      ext_d       = ext_q;
      brk_d       = brk_q;
      key_held_d  = key_held_q;
      key_pulse_d = 1'b0;
      if (frame_error_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (scan_valid_q) begin
         case (scan_code_q)
            SC_EXT:   ext_d = 1'b1;
            SC_BREAK: brk_d = 1'b1;
            default: begin
               if (!ext_q && scan_code_q == KEY_CODE) begin
                  if (brk_q) begin
                     key_held_d = 1'b0;
                  end else if (!key_held_q) begin
                     key_pulse_d = 1'b1;
                     key_held_d  = 1'b1;
                  end
               end
               ext_d = 1'b0;
               brk_d = 1'b0;
            end
         endcase
      end
   end

   assign key_pulse   = key_pulse_q;
   assign key_held    = key_held_q;
   assign scan_code   = scan_code_q;
   assign scan_valid  = scan_valid_q;
   assign frame_error = frame_error_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus queues expected events, a monitor pops them.
module tb_ps2_key_decoder;
   import ps2_pkg::*;

   localparam int TO = 2000;
   localparam int HP = 30;

   logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic       key_pulse, key_held, scan_valid, frame_error;
   logic [7:0] scan_code;

   int         n_chk = 0, n_pass = 0;
   logic [9:0] exp_q[$];

   ps2_key_decoder #(.KEY_CODE(8'h29), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_pulse(key_pulse), .key_held(key_held), .scan_code(scan_code),
      .scan_valid(scan_valid), .frame_error(frame_error)
   );

   always #8 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic ev(input logic [9:0] a);
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL unexpected_event: got %0h, expected none", a);
      end else begin
         chk("event", {22'd0, a}, {22'd0, exp_q.pop_front()});
      end
   endtask

   // Event tags: {kind, value}; kind 0 = scan byte, 1 = frame error, 2 = key pulse (value = key_held).
   always @(negedge clk) begin
      if (!reset) begin
         if (scan_valid)  ev({2'd0, scan_code});
         if (frame_error) ev({2'd1, 8'd0});
         if (key_pulse)   ev({2'd2, 7'd0, key_held});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic exp_sv(input logic [7:0] b);
      exp_q.push_back({2'd0, b});
   endtask
   task automatic exp_er();
      exp_q.push_back({2'd1, 8'd0});
   endtask
   task automatic exp_kp();
      exp_q.push_back({2'd2, 8'd1});
   endtask

   task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         cyc(HP / 2);
         ps2_data = f[i];
         cyc(HP / 2);
         ps2_clk = 1'b0;
         cyc(HP);
         ps2_clk = 1'b1;
      end
      cyc(HP / 2);
      ps2_data = 1'b1;
      cyc(2 * HP);
   endtask

   task automatic good(input logic [7:0] b);
      send(b, 1'b0, 1'b0, FRAME_BITS);
   endtask

   initial begin
      cyc(5);
      chk("reset_outputs", {23'd0, key_pulse, key_held, scan_valid, frame_error, scan_code}, 32'd0);
      reset = 1'b0;
      cyc(5);

      exp_sv(8'h29); exp_kp(); good(8'h29);
      chk("held_after_make", {31'd0, key_held}, 32'd1);

      for (int i = 0; i < 3; i++) begin
         exp_sv(8'h29); good(8'h29);
      end
      chk("held_after_typematic", {31'd0, key_held}, 32'd1);

      exp_sv(8'hF0); good(8'hF0);
      exp_sv(8'h29); good(8'h29);
      chk("held_after_break", {31'd0, key_held}, 32'd0);
      exp_sv(8'h29); exp_kp(); good(8'h29);
      chk("held_after_remake", {31'd0, key_held}, 32'd1);

      exp_sv(8'hE0); good(8'hE0);
      exp_sv(8'h29); good(8'h29);
      chk("held_after_ext_make", {31'd0, key_held}, 32'd1);
      exp_sv(8'hE0); good(8'hE0);
      exp_sv(8'hF0); good(8'hF0);
      exp_sv(8'h29); good(8'h29);
      chk("held_after_ext_break", {31'd0, key_held}, 32'd1);

      exp_er(); send(8'h29, 1'b1, 1'b0, FRAME_BITS);
      chk("code_after_parity_err", {24'd0, scan_code}, 32'h29);
      exp_er(); send(8'h29, 1'b0, 1'b1, FRAME_BITS);
      chk("code_after_stop_err", {24'd0, scan_code}, 32'h29);

      exp_er(); send(8'h5A, 1'b0, 1'b0, 5);
      cyc(TO + 100);
      exp_sv(8'h1C); good(8'h1C);
      chk("code_after_timeout", {24'd0, scan_code}, 32'h1C);
      chk("held_after_timeout", {31'd0, key_held}, 32'd1);

      send(8'h29, 1'b0, 1'b0, 4);
      reset = 1'b1;
      cyc(3);
      chk("midframe_reset_outputs", {23'd0, key_pulse, key_held, scan_valid, frame_error, scan_code}, 32'd0);
      reset = 1'b0;
      cyc(300);
      exp_sv(8'h29); exp_kp(); good(8'h29);
      chk("held_after_reset_make", {31'd0, key_held}, 32'd1);

      cyc(50);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
